fme_argmin_pipe: RTL
====================

FME_ARGMIN_PIPE -- requirements
Module: fme_argmin_pipe

Interface
REQ-001 Parameter N_CAND, default 9: candidate distortions per input vector; legal range 2..16.
REQ-002 Parameter COST_W, default 16: width of each unsigned distortion.
REQ-003 Parameter MAX_BATCH, default 4: maximum vectors per search group; legal range 1..8.
REQ-004 Derived constant IDX_W = clog2(N_CAND*MAX_BATCH): global index width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  in_cost/in_first/in_last are valid.
REQ-008 in_ready  output  1  block accepts the vector this cycle.
REQ-009 in_cost  input  N_CAND x COST_W  packed array; element k is the distortion of candidate k.
REQ-010 in_first  input  1  vector starts a new search group.
REQ-011 in_last  input  1  vector closes the current search group.
REQ-012 out_valid  output  1  group result available.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_idx  output  IDX_W  global winner index = batch_number*N_CAND + local index.
REQ-015 out_cost  output  COST_W  winning distortion.
REQ-016 out_ovf  output  1  group was force-closed at MAX_BATCH (REQ-027).

Function
REQ-017 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-018 Argmin via binary compare tree of S = clog2(N_CAND) levels, one register stage per level; an odd element passes through a level unchanged.
REQ-019 Comparison unsigned, a <= b selects a; ties resolve to the lower local index, and across batches to the earlier batch.
REQ-020 Accumulate stage after the tree keeps a running min (cost, global index) and a batch counter (0..MAX_BATCH-1).
REQ-021 Latency, no stall: group with last vector accepted in cycle t gives out_valid in cycle t+S+1.
REQ-022 Accepting in_first: running min loaded from the tree result, batch counter = 0, local index unchanged.
REQ-023 Later vectors: batch counter increments; tree result replaces running min only if strictly lower.
REQ-024 in_first && in_last together: single-vector group; result equals tree result.
REQ-025 A non-first vector arriving with no group open: treated as in_first.
REQ-026 Global stall: pipeline holds when out_valid && !out_ready; in_ready = !(out_valid && !out_ready); out_idx/out_cost/out_ovf stable while stalled.
REQ-027 Group reaching MAX_BATCH vectors without in_last: force-closed on the last one, out_ovf = 1; next vector implicitly starts a new group.
REQ-028 Empty pipeline bubbles (in_valid = 0) advance without changing accumulator state.
REQ-029 Back-to-back groups of one vector sustain one result per cycle when out_ready = 1.

Reset
REQ-030 rst_n low: all stage valids, out_valid, out_ovf, batch counter and group-open flag clear immediately; out_idx = 0, out_cost = 0.
REQ-031 Reset mid-group or mid-stall: in-flight data discarded; no partial result after rst_n rises.
REQ-032 First acceptance possible on the first rising clk edge after rst_n deasserts; in_ready = 1 then.

Structure
REQ-033 fme_pkg holds the default N_CAND/COST_W/MAX_BATCH values, the IDX_W function and the (cost, index) pair typedef.
REQ-034 One sub-module, fme_min2: registered two-input min of (cost, index) pairs with enable; instantiated per tree node.

Verification
REQ-035 Single vector {5,3,7,3,9,8,6,4,2} first&last -> out_idx=8, out_cost=2, S+1=5 cycles after acceptance.
REQ-036 All nine costs = 0x0010, first&last -> out_idx=0, out_cost=0x0010 (tie rule).
REQ-037 Group of 3: batch0 min 20 at k=4, batch1 min 12 at k=2, batch2 min 12 at k=0 -> out_idx=11, out_cost=12, out_ovf=0.
REQ-038 5 vectors, none with in_last, MAX_BATCH=4 -> result after the 4th with out_ovf=1; 5th starts a new group.
REQ-039 out_ready held low 6 cycles with in_valid=1 -> in_ready=0, outputs stable, no loss or duplication after release.
REQ-040 rst_n pulsed low mid-group and mid-stall -> out_valid=0 at once; next group result unaffected by pre-reset data.

Source files
------------

// File: rtl/fme_pkg.sv
// rtl/fme_pkg.sv - shared defaults, width helpers and (cost, index) pair type for the argmin pipe
package fme_pkg;

    localparam int N_CAND_DEF    = 9;
    localparam int COST_W_DEF    = 16;
    localparam int MAX_BATCH_DEF = 4;

    // Global index width: enough to address every candidate of a full group.
    function automatic int idx_w(input int n_cand, input int max_batch);
        return $clog2(n_cand * max_batch);
    endfunction

    // Number of live entries after lvl compare levels (odd entries round up).
    function automatic int lvl_width(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    localparam int IDX_W_DEF = idx_w(N_CAND_DEF, MAX_BATCH_DEF);

    typedef struct packed {
        logic [COST_W_DEF-1:0] cost;
        logic [IDX_W_DEF-1:0]  idx;
    } cand_t;

endpackage

// File: rtl/fme_argmin_pipe_if.sv
// rtl/fme_argmin_pipe_if.sv - candidate-vector input and group-result output handshake bundle
// master: producer/consumer side (drives in_*, out_ready); slave: the argmin pipe.
interface fme_argmin_pipe_if #(
    parameter int N_CAND = 9,
    parameter int COST_W = 16,
    parameter int IDX_W  = 6
);
    logic                           in_valid;
    logic                           in_ready;
    logic [N_CAND-1:0][COST_W-1:0]  in_cost;
    logic                           in_first;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [IDX_W-1:0]               out_idx;
    logic [COST_W-1:0]              out_cost;
    logic                           out_ovf;

    modport master (
        output in_valid, in_cost, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_idx, out_cost, out_ovf
    );

    modport slave (
        input  in_valid, in_cost, in_first, in_last, out_ready,
        output in_ready, out_valid, out_idx, out_cost, out_ovf
    );
endinterface

// File: rtl/fme_min2.sv
// rtl/fme_min2.sv - registered two-input min of (cost, index) pairs with enable
// Ports: clk, rst_n, en (hold when low), a_*/b_* operand pairs, y_* registered winner.
// a wins ties, so wiring the lower-index operand to a keeps the lower index on ties.
module fme_min2 #(
    parameter int COST_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [COST_W-1:0] a_cost,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [COST_W-1:0] b_cost,
    input  logic [IDX_W-1:0]  b_idx,
    output logic [COST_W-1:0] y_cost,
    output logic [IDX_W-1:0]  y_idx
);
    logic [COST_W-1:0] y_cost_q, y_cost_d;
    logic [IDX_W-1:0]  y_idx_q,  y_idx_d;

    always_comb begin
        y_cost_d = y_cost_q;
        y_idx_d  = y_idx_q;
        if (en) begin
            if (a_cost <= b_cost) begin
                y_cost_d = a_cost;
                y_idx_d  = a_idx;
            end else begin
                y_cost_d = b_cost;
                y_idx_d  = b_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cost_q <= '0;
            y_idx_q  <= '0;
        end else begin
            y_cost_q <= y_cost_d;
            y_idx_q  <= y_idx_d;
        end
    end

    assign y_cost = y_cost_q;
    assign y_idx  = y_idx_q;
endmodule

// File: rtl/fme_argmin_pipe.sv
// rtl/fme_argmin_pipe.sv - pipelined argmin over candidate vectors with multi-vector group accumulation
// Ports: clk, rst_n (async, active-low), bus (slave): in_valid/in_ready/in_cost/in_first/in_last
// vector input, out_valid/out_ready/out_idx/out_cost/out_ovf group result.
module fme_argmin_pipe
    import fme_pkg::*;
#(
    parameter int N_CAND    = N_CAND_DEF,
    parameter int COST_W    = COST_W_DEF,
    parameter int MAX_BATCH = MAX_BATCH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    fme_argmin_pipe_if.slave   bus
);
    localparam int IDX_W  = idx_w(N_CAND, MAX_BATCH);
    localparam int S      = $clog2(N_CAND);
    localparam int LIDX_W = S;
    localparam int BW     = (MAX_BATCH > 1) ? $clog2(MAX_BATCH) : 1;

    // Whole pipeline freezes while a result waits for the consumer.
    logic adv;
    assign adv = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;

    // Compare tree: level 0 is the input vector, level l holds lvl_width(N_CAND, l) live pairs.
    logic [COST_W-1:0] lv_cost [S+1][N_CAND];
    logic [LIDX_W-1:0] lv_idx  [S+1][N_CAND];

    for (genvar j = 0; j < N_CAND; j++) begin : g_in
        assign lv_cost[0][j] = bus.in_cost[j];
        assign lv_idx[0][j]  = LIDX_W'(j);
    end

    for (genvar l = 1; l <= S; l++) begin : g_lvl
        localparam int W_IN  = lvl_width(N_CAND, l - 1);
        localparam int W_OUT = lvl_width(N_CAND, l);
        for (genvar j = 0; j < N_CAND; j++) begin : g_node
            if (j < W_OUT) begin : g_cmp
                // An unpaired trailing entry is compared against itself, i.e. passed through.
                localparam int B = (2*j + 1 < W_IN) ? 2*j + 1 : 2*j;
                fme_min2 #(.COST_W(COST_W), .IDX_W(LIDX_W)) u_min2 (
                    .clk    (clk),
                    .rst_n  (rst_n),
                    .en     (adv),
                    .a_cost (lv_cost[l-1][2*j]),
                    .a_idx  (lv_idx[l-1][2*j]),
                    .b_cost (lv_cost[l-1][B]),
                    .b_idx  (lv_idx[l-1][B]),
                    .y_cost (lv_cost[l][j]),
                    .y_idx  (lv_idx[l][j])
                );
            end else begin : g_pad
                assign lv_cost[l][j] = '0;
                assign lv_idx[l][j]  = '0;
            end
        end
    end

    // Sideband travelling alongside the tree; bit i is the stage after level i+1.
    logic [S-1:0] v_q, v_d, first_q, first_d, last_q, last_d;

    always_comb begin
        v_d     = v_q;
        first_d = first_q;
        last_d  = last_q;
        if (adv) begin
            for (int i = S - 1; i > 0; i--) begin
                v_d[i]     = v_q[i-1];
                first_d[i] = first_q[i-1];
                last_d[i]  = last_q[i-1];
            end
            v_d[0]     = bus.in_valid;
            first_d[0] = bus.in_first;
            last_d[0]  = bus.in_last;
        end
    end

    // Accumulate stage.
    logic [COST_W-1:0] run_cost_q, run_cost_d, out_cost_q, out_cost_d, sel_cost;
    logic [IDX_W-1:0]  run_idx_q,  run_idx_d,  out_idx_q,  out_idx_d,  sel_idx, t_gidx;
    logic [BW-1:0]     batch_q, batch_d, batch_nx;
    logic              open_q, open_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic              start, at_max, close;

    always_comb begin
        // A vector with no group open starts one, whatever its in_first says.
        start    = first_q[S-1] || !open_q;
        batch_nx = start ? '0 : batch_q + 1'b1;
        t_gidx   = IDX_W'(batch_nx) * IDX_W'(N_CAND) + IDX_W'(lv_idx[S][0]);
        // Strictly-lower replacement keeps the earlier batch on ties.
        if (start || (lv_cost[S][0] < run_cost_q)) begin
            sel_cost = lv_cost[S][0];
            sel_idx  = t_gidx;
        end else begin
            sel_cost = run_cost_q;
            sel_idx  = run_idx_q;
        end
        at_max = (batch_nx == BW'(MAX_BATCH - 1));
        close  = last_q[S-1] || at_max;

        run_cost_d  = run_cost_q;
        run_idx_d   = run_idx_q;
        batch_d     = batch_q;
        open_d      = open_q;
        out_valid_d = out_valid_q;
        out_cost_d  = out_cost_q;
        out_idx_d   = out_idx_q;
        out_ovf_d   = out_ovf_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (v_q[S-1]) begin
                run_cost_d = sel_cost;
                run_idx_d  = sel_idx;
                batch_d    = batch_nx;
                open_d     = !close;
                if (close) begin
                    out_valid_d = 1'b1;
                    out_cost_d  = sel_cost;
                    out_idx_d   = sel_idx;
                    out_ovf_d   = !last_q[S-1] && at_max;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= '0;
            first_q     <= '0;
            last_q      <= '0;
            run_cost_q  <= '0;
            run_idx_q   <= '0;
            batch_q     <= '0;
            open_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_cost_q  <= '0;
            out_idx_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            v_q         <= v_d;
            first_q     <= first_d;
            last_q      <= last_d;
            run_cost_q  <= run_cost_d;
            run_idx_q   <= run_idx_d;
            batch_q     <= batch_d;
            open_q      <= open_d;
            out_valid_q <= out_valid_d;
            out_cost_q  <= out_cost_d;
            out_idx_q   <= out_idx_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_cost  = out_cost_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
